// File: rtl/univ_count_shift_if.sv
// Operation/result bundle for the universal counter/shifter.
// The master drives the controls and observes the register; the slave is the unit itself.
interface univ_count_shift_if #(
  parameter int WIDTH = 8
);
  logic             En;
  logic [3:0]       Mode;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Limit;
  logic             R_In;
  logic             L_In;
  logic [WIDTH-1:0] Out;
  logic             Tc;
  logic             ShOut;
  logic             Zero;

  modport master (
    output En, Mode, Din, Limit, R_In, L_In,
    input  Out, Tc, ShOut, Zero
  );

  modport slave (
    input  En, Mode, Din, Limit, R_In, L_In,
    output Out, Tc, ShOut, Zero
  );
endinterface

// File: rtl/univ_count_shift.sv
// WIDTH-bit register/counter/shifter: load, wrap/modulo/saturating counts, shifts,
// rotates, complement and half-swap, with registered Tc/ShOut flags and a Zero flag.
module univ_count_shift #(
  parameter int WIDTH = 8
) (
  input  logic              Ck,
  input  logic              Reset,
  univ_count_shift_if.slave bus
);

  typedef enum logic [3:0] {
    MODE_HOLD     = 4'h0,
    MODE_LOAD     = 4'h1,
    MODE_UP       = 4'h2,
    MODE_DOWN     = 4'h3,
    MODE_SHR      = 4'h4,
    MODE_SHL      = 4'h5,
    MODE_COMP     = 4'h6,
    MODE_SWAP     = 4'h7,
    MODE_ROR      = 4'h8,
    MODE_ROL      = 4'h9,
    MODE_ASR      = 4'hA,
    MODE_UP_MOD   = 4'hB,
    MODE_DOWN_MOD = 4'hC,
    MODE_SAT_UP   = 4'hD,
    MODE_SAT_DOWN = 4'hE,
    MODE_CLR      = 4'hF
  } mode_e;

  localparam int               HALF     = WIDTH / 2;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             shout_q, shout_d;

  mode_e            mode;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;
  logic [WIDTH-1:0] swap_val;
  logic             out_is_max;
  logic             out_is_zero;

  assign mode        = mode_e'(bus.Mode);
  assign inc_val     = out_q + ONE;
  assign dec_val     = out_q - ONE;
  assign out_is_max  = (out_q == ALL_ONES);
  assign out_is_zero = (out_q == '0);

  // Half-swap: bit gi of the result comes from the opposite half.
  for (genvar gi = 0; gi < HALF; gi++) begin : g_swap
    assign swap_val[gi]        = out_q[gi + HALF];
    assign swap_val[gi + HALF] = out_q[gi];
  end

  always_comb begin
    out_d   = out_q;
    tc_d    = 1'b0;
    shout_d = 1'b0;
    if (bus.En) begin
      unique case (mode)
        MODE_HOLD: out_d = out_q;
        MODE_LOAD: out_d = bus.Din;
        MODE_UP: begin
          out_d = inc_val;
          tc_d  = out_is_max;
        end
        MODE_DOWN: begin
          out_d = dec_val;
          tc_d  = out_is_zero;
        end
        MODE_SHR: begin
          out_d   = {bus.L_In, out_q[WIDTH-1:1]};
          shout_d = out_q[0];
        end
        MODE_SHL: begin
          out_d   = {out_q[WIDTH-2:0], bus.R_In};
          shout_d = out_q[WIDTH-1];
        end
        MODE_COMP: out_d = ~out_q;
        MODE_SWAP: out_d = swap_val;
        MODE_ROR:  out_d = {out_q[0], out_q[WIDTH-1:1]};
        MODE_ROL:  out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
        MODE_ASR: begin
          out_d   = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
          shout_d = out_q[0];
        end
        MODE_UP_MOD: begin
          // >= rather than == so an out-of-range value after a Limit change recovers.
          if (out_q >= bus.Limit) begin
            out_d = '0;
            tc_d  = 1'b1;
          end else begin
            out_d = inc_val;
          end
        end
        MODE_DOWN_MOD: begin
          if (out_is_zero || (out_q > bus.Limit)) begin
            out_d = bus.Limit;
            tc_d  = 1'b1;
          end else begin
            out_d = dec_val;
          end
        end
        MODE_SAT_UP: begin
          out_d = out_is_max ? out_q : inc_val;
          tc_d  = (out_d == ALL_ONES);
        end
        MODE_SAT_DOWN: begin
          out_d = out_is_zero ? out_q : dec_val;
          tc_d  = (out_d == '0);
        end
        MODE_CLR: out_d = '0;
      endcase
    end
  end

  always_ff @(posedge Ck) begin
    if (Reset) begin
      out_q   <= '0;
      tc_q    <= 1'b0;
      shout_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      tc_q    <= tc_d;
      shout_q <= shout_d;
    end
  end

  assign bus.Out   = out_q;
  assign bus.Tc    = tc_q;
  assign bus.ShOut = shout_q;
  assign bus.Zero  = (out_q == '0);

endmodule

// File: doc/univ_count_shift.md
Name: univ_count_shift

Overview:
Parametrised next-generation register/counter unit: a WIDTH-bit register with load, up/down counting, modulo and saturating counting, logical/arithmetic shifts, rotates, complement and half-swap.
Adds a clock enable, registered wrap/terminal-count and shift-out flags, and a zero flag.
Used as the general-purpose counter/shifter primitive in datapath and timing blocks.

Parameters:
WIDTH, 8, register width in bits; must be even and >= 2.

Ports:
Ck  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous reset, active-high
En  input  1  clock enable; 0 = hold register, clear flags
Mode  input  4  operation select (encoding below)
Din  input  WIDTH  parallel load data
Limit  input  WIDTH  modulo bound for UP_MOD/DOWN_MOD
R_In  input  1  serial in for left shift
L_In  input  1  serial in for right shift
Out  output  WIDTH  register contents
Tc  output  1  registered terminal-count/wrap pulse
ShOut  output  1  registered bit shifted out by last SHR/SHL/ASR
Zero  output  1  combinational, 1 when Out == 0

Behaviour:
- Reset (takes priority over En and Mode): Out=0, Tc=0, ShOut=0.
- En=0: Out holds; Tc and ShOut are cleared to 0.
- En=1: one operation per edge; result visible on Out the next cycle (latency 1).
- Mode encoding:
  - 0000 HOLD: Out holds.
  - 0001 LOAD: Out<=Din.
  - 0010 UP: Out+1 mod 2^WIDTH; Tc=1 if old Out was all-ones.
  - 0011 DOWN: Out-1 mod 2^WIDTH; Tc=1 if old Out was 0.
  - 0100 SHR: {L_In, Out[W-1:1]}; ShOut<=old Out[0].
  - 0101 SHL: {Out[W-2:0], R_In}; ShOut<=old Out[W-1].
  - 0110 COMP: ~Out.
  - 0111 SWAP: upper and lower halves exchanged.
  - 1000 ROR: {Out[0], Out[W-1:1]}.
  - 1001 ROL: {Out[W-2:0], Out[W-1]}.
  - 1010 ASR: {Out[W-1], Out[W-1:1]}; ShOut<=old Out[0].
  - 1011 UP_MOD: if old Out >= Limit then 0 with Tc=1, else Out+1.
  - 1100 DOWN_MOD: if old Out==0 or old Out > Limit then Limit with Tc=1, else Out-1.
  - 1101 SAT_UP: Out+1, stops at all-ones; Tc=1 while the result is all-ones.
  - 1110 SAT_DOWN: Out-1, stops at 0; Tc=1 while the result is 0.
  - 1111 CLR: Out<=0.
- Flag rules:
  - Tc is a registered flag: high exactly in the cycle after a qualifying edge, otherwise 0.
  - ShOut updates only on SHR/SHL/ASR; it is 0 after any other mode.
- Limit=0: UP_MOD and DOWN_MOD hold Out at 0 and Tc=1 every enabled cycle.
- Limit is sampled on the same edge as the operation; changing Limit mid-count takes effect immediately, and out-of-range values recover via the >= / > rules above.
- Arithmetic is unsigned, WIDTH bits, no carry beyond Tc.
- Reset asserted mid-count: next edge Out=0 regardless of Mode/En; counting resumes from 0 on the first edge with Reset=0.

Test Plan:
- Reset/LOAD: Reset=1 for 2 edges -> Out=0x00, Tc=0, Zero=1; then En=1, LOAD Din=0xA5 -> Out=0xA5, Zero=0.
- UP/DOWN wrap:
  - LOAD 0xFE, UP x2 -> Out 0xFF then 0x00, Tc=1 only in the cycle after the 2nd edge.
  - DOWN from 0x00 -> 0xFF, Tc=1.
- Modulo: Limit=5, LOAD 0, UP_MOD x7 -> 1,2,3,4,5,0,1, Tc pulse after the 6th edge; LOAD 9, DOWN_MOD -> 5 with Tc=1; Limit=0 -> Out stays 0, Tc=1 each cycle.
- Shifts:
  - LOAD 0x81, SHR L_In=1 -> 0xC0, ShOut=1.
  - ASR on 0x80 -> 0xC0, ShOut=0.
  - SHL R_In=0 on 0x81 -> 0x02, ShOut=1.
  - ROL 0x81 -> 0x03; ROR 0x81 -> 0xC0.
- Misc: SWAP 0x3C -> 0xC3; COMP 0x3C -> 0xC3; SAT_UP from 0xFE x3 -> 0xFF,0xFF,0xFF, Tc=1 each; SAT_DOWN from 0x01 x2 -> 0x00,0x00; CLR -> 0.
- Enable/reset priority: En=0 with Mode=UP for 3 edges -> Out unchanged, Tc=0, ShOut=0; Reset=1 with En=1, Mode=LOAD, Din=0xFF -> Out=0x00.
